// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the SPU odd-pipe branch redirect controller.
package spu_branch_pkg;
  localparam int PC_W_DEFAULT = 8;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT, REFILL} br_state_t;
  typedef logic [PC_W_DEFAULT-1:0] pc_t;
endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating event counter used for the optional branch statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// PC redirect sequencer after a resolved taken branch (IDLE/FLUSH/REDIRECT/REFILL).
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl
  import spu_branch_pkg::*;
#(
  parameter int PC_W          = PC_W_DEFAULT,
  parameter int REFILL_CYCLES = 2,
  parameter int FLUSH_STAGES  = 3,
  parameter int CNT_W         = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    br_valid,
  input  logic                    br_taken,
  input  logic [PC_W-1:0]         br_target,
  input  logic                    br_first,
  input  logic                    fetch_ready,
  output logic                    redirect_valid,
  output logic [PC_W-1:0]         redirect_pc,
  output logic                    kill_twin,
  output logic [FLUSH_STAGES-1:0] flush_vec,
  output logic                    stall_issue,
  output logic                    busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]        taken_cnt,
  output logic [CNT_W-1:0]        not_taken_cnt,
  output logic [CNT_W-1:0]        stall_cnt
`endif
);
  localparam int RC_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = (REFILL_CYCLES > 0) ? RC_W'(REFILL_CYCLES - 1) : '0;

  br_state_t       state_q, state_d;
  logic [RC_W-1:0] refill_cnt_q;
  logic [PC_W-1:0] target_q;
  logic            first_q;
  logic            accept;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        // Results arriving in any other state are wrong-path and dropped.
        if (br_valid && br_taken) begin
          state_d = FLUSH;
          accept  = 1'b1;
        end
      end
      FLUSH:    state_d = REDIRECT;
      REDIRECT: if (fetch_ready) state_d = (REFILL_CYCLES == 0) ? IDLE : REFILL;
      REFILL:   if (refill_cnt_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      refill_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == REDIRECT && fetch_ready)
        refill_cnt_q <= RC_LOAD;
      else if (state_q == REFILL && refill_cnt_q != '0)
        refill_cnt_q <= refill_cnt_q - RC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      target_q <= br_target;
      first_q  <= br_first;
    end
  end

  // Outputs decode the state flops only; the latched target is gated so reset shows 0.
  assign busy           = (state_q != IDLE);
  assign stall_issue    = busy;
  assign flush_vec      = {FLUSH_STAGES{state_q == FLUSH}};
  assign kill_twin      = (state_q == FLUSH) && first_q;
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_valid ? target_q : '0;

`ifdef BRANCH_STATS_EN
  logic taken_inc, not_taken_inc;
  assign taken_inc     = (state_q == IDLE) && br_valid && br_taken;
  assign not_taken_inc = (state_q == IDLE) && br_valid && !br_taken;

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clock(clock), .reset(reset), .inc(taken_inc), .count(taken_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_not_taken_cnt (
    .clock(clock), .reset(reset), .inc(not_taken_inc), .count(not_taken_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock(clock), .reset(reset), .inc(stall_issue), .count(stall_cnt));
`endif
endmodule
